// File: rtl/memory_access_controller_if.sv
// Bus between the control unit / memory and the memory access controller.
// start_read/start_write are level requests sampled only while the controller is
// idle; mem_ready is the memory's acknowledge, sampled on each rising edge while a
// strobe (mem_read/mem_write) is held; a strobe stays high until that ack or a timeout.
interface memory_access_controller_if;
  logic       start_read;
  logic       start_write;
  logic       mem_ready;
  logic       mar_en;
  logic       mdr_en;
  logic       mdr_read;
  logic       mem_read;
  logic       mem_write;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_dbg;

  modport slave (
    input  start_read, start_write, mem_ready,
    output mar_en, mdr_en, mdr_read, mem_read, mem_write, busy, done, err, state_dbg
  );

  modport master (
    output start_read, start_write, mem_ready,
    input  mar_en, mdr_en, mdr_read, mem_read, mem_write, busy, done, err, state_dbg
  );
endinterface

// File: rtl/memory_access_controller.sv
// Sequences MAR/MDR loads and memory read/write strobes for one access at a time,
// aborting with a one-cycle err pulse if memory does not acknowledge in TIMEOUT cycles.
module memory_access_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        clr,
    memory_access_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MAR_LOAD = 3'd1,
        RD_REQ   = 3'd2,
        RD_LATCH = 3'd3,
        WR_REQ   = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       op_write;
    logic [7:0] cnt;
    logic       in_req;
    logic       timed_out;

    logic mar_en_c, mdr_en_c, mdr_read_c, mem_read_c, mem_write_c, busy_c, done_c, err_c;

    assign in_req    = (state == RD_REQ) || (state == WR_REQ);
    // A late ack on the last allowed cycle still completes normally.
    assign timed_out = (cnt == TO_LAST) && !bus.mem_ready;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            op_write <= 1'b0;
            cnt      <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (bus.start_read || bus.start_write))
                op_write <= !bus.start_read;
            if (in_req && !bus.mem_ready)
                cnt <= cnt + 8'd1;
            else
                cnt <= 8'd0;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (bus.start_read || bus.start_write) state_nxt = MAR_LOAD;
                else                                   state_nxt = IDLE;
            end
            MAR_LOAD: state_nxt = op_write ? WR_REQ : RD_REQ;
            RD_REQ: begin
                if (bus.mem_ready)  state_nxt = RD_LATCH;
                else if (timed_out) state_nxt = ERR;
                else                state_nxt = RD_REQ;
            end
            RD_LATCH: state_nxt = DONE;
            WR_REQ: begin
                if (bus.mem_ready)  state_nxt = DONE;
                else if (timed_out) state_nxt = ERR;
                else                state_nxt = WR_REQ;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mar_en_c    = 1'b0;
        mdr_en_c    = 1'b0;
        mdr_read_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        done_c      = 1'b0;
        err_c       = 1'b0;
        busy_c      = (state != IDLE);
        case (state)
            MAR_LOAD: mar_en_c = 1'b1;
            RD_REQ:   mem_read_c = 1'b1;
            RD_LATCH: begin
                mem_read_c = 1'b1;
                mdr_en_c   = 1'b1;
                mdr_read_c = 1'b1;
            end
            // MDR stays frozen so it supplies the write data.
            WR_REQ:   mem_write_c = 1'b1;
            DONE:     done_c = 1'b1;
            ERR:      err_c = 1'b1;
            default:  ;
        endcase
    end

    assign bus.mar_en    = mar_en_c;
    assign bus.mdr_en    = mdr_en_c;
    assign bus.mdr_read  = mdr_read_c;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.err       = err_c;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed cycle-by-cycle bench for memory_access_controller (TIMEOUT=4):
// vector table for the main sequences, hand-written sequence for async reset abort.
module tb_memory_access_controller;

  logic clk;
  logic clr;

  memory_access_controller_if bus ();

  memory_access_controller #(.TIMEOUT(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit order: mar_en, mdr_en, mdr_read, mem_read, mem_write, busy, done, err
  logic [7:0] out_v;
  assign out_v = {bus.mar_en, bus.mdr_en, bus.mdr_read, bus.mem_read,
                  bus.mem_write, bus.busy, bus.done, bus.err};

  localparam logic [7:0] O_IDLE  = 8'h00;
  localparam logic [7:0] O_MAR   = 8'h84;
  localparam logic [7:0] O_RDREQ = 8'h14;
  localparam logic [7:0] O_RDLAT = 8'h74;
  localparam logic [7:0] O_WRREQ = 8'h0C;
  localparam logic [7:0] O_DONE  = 8'h06;
  localparam logic [7:0] O_ERR   = 8'h05;

  typedef struct {
    string      tag;
    logic       sr;
    logic       sw;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  // ---- scoreboard ----
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_invariants(input string name);
    logic [1:0] viol;
    viol = {bus.mem_read & bus.mem_write, bus.mar_en & (bus.mem_read | bus.mem_write)};
    check({name, "_excl"}, {6'd0, viol}, 8'd0);
  endtask

  function automatic void add(input string tag, input logic sr, input logic sw,
                              input logic rdy, input logic [7:0] exp);
    vec_t v;
    v.tag = tag; v.sr = sr; v.sw = sw; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // ---- driver ----
  task automatic drive(input logic sr, input logic sw, input logic rdy);
    bus.start_read  = sr;
    bus.start_write = sw;
    bus.mem_ready   = rdy;
  endtask

  initial begin
    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // Reset state, including a start request that must be ignored under reset.
    repeat (2) @(negedge clk);
    check("reset_outputs", out_v, O_IDLE);
    check("reset_state", {5'd0, bus.state_dbg}, 8'd0);
    drive(1'b1, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    check("reset_ignores_start", out_v, O_IDLE);
    drive(1'b0, 1'b0, 1'b0);
    clr = 1'b1;

    // Best-case read, mem_ready tied high.
    add("rd_fast", 1, 0, 1, O_IDLE);
    add("rd_fast", 0, 0, 1, O_MAR);
    add("rd_fast", 0, 0, 1, O_RDREQ);
    add("rd_fast", 0, 0, 1, O_RDLAT);
    add("rd_fast", 0, 0, 1, O_DONE);
    add("rd_fast", 0, 0, 1, O_IDLE);
    // Write, ready rises on the 4th WR_REQ cycle (also the exact timeout cycle).
    add("wr_slow", 0, 1, 0, O_IDLE);
    add("wr_slow", 0, 0, 0, O_MAR);
    add("wr_slow", 0, 0, 0, O_WRREQ);
    add("wr_slow", 0, 0, 0, O_WRREQ);
    add("wr_slow", 0, 0, 0, O_WRREQ);
    add("wr_slow", 0, 0, 1, O_WRREQ);
    add("wr_slow", 0, 0, 0, O_DONE);
    add("wr_slow", 0, 0, 0, O_IDLE);
    // Read timeout: 4 cycles of mem_read, then err, no done.
    add("rd_tmo", 1, 0, 0, O_IDLE);
    add("rd_tmo", 0, 0, 0, O_MAR);
    add("rd_tmo", 0, 0, 0, O_RDREQ);
    add("rd_tmo", 0, 0, 0, O_RDREQ);
    add("rd_tmo", 0, 0, 0, O_RDREQ);
    add("rd_tmo", 0, 0, 0, O_RDREQ);
    add("rd_tmo", 0, 0, 0, O_ERR);
    add("rd_tmo", 0, 0, 0, O_IDLE);
    add("rd_tmo", 0, 0, 0, O_IDLE);
    // Read with ack on the exact timeout cycle completes normally.
    add("rd_edge", 1, 0, 0, O_IDLE);
    add("rd_edge", 0, 0, 0, O_MAR);
    add("rd_edge", 0, 0, 0, O_RDREQ);
    add("rd_edge", 0, 0, 0, O_RDREQ);
    add("rd_edge", 0, 0, 0, O_RDREQ);
    add("rd_edge", 0, 0, 1, O_RDREQ);
    add("rd_edge", 0, 0, 0, O_RDLAT);
    add("rd_edge", 0, 0, 0, O_DONE);
    add("rd_edge", 0, 0, 0, O_IDLE);
    // Both starts high: read wins, write dropped.
    add("both", 1, 1, 1, O_IDLE);
    add("both", 0, 0, 1, O_MAR);
    add("both", 0, 0, 1, O_RDREQ);
    add("both", 0, 0, 1, O_RDLAT);
    add("both", 0, 0, 1, O_DONE);
    add("both", 0, 0, 1, O_IDLE);
    // start_write during a read is ignored.
    add("ignore", 1, 0, 1, O_IDLE);
    add("ignore", 0, 0, 1, O_MAR);
    add("ignore", 0, 1, 1, O_RDREQ);
    add("ignore", 0, 1, 1, O_RDLAT);
    add("ignore", 0, 0, 1, O_DONE);
    add("ignore", 0, 0, 1, O_IDLE);
    // Back-to-back writes with start_write held through DONE.
    add("b2b", 0, 1, 1, O_IDLE);
    add("b2b", 0, 1, 1, O_MAR);
    add("b2b", 0, 1, 1, O_WRREQ);
    add("b2b", 0, 1, 1, O_DONE);
    add("b2b", 0, 1, 1, O_IDLE);
    add("b2b", 0, 0, 1, O_MAR);
    add("b2b", 0, 0, 1, O_WRREQ);
    add("b2b", 0, 0, 1, O_DONE);
    add("b2b", 0, 0, 0, O_IDLE);

    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);

    foreach (vecs[i]) begin
      logic [7:0] e;
      string      nm;
      @(posedge clk); #1;
      drive(vecs[i].sr, vecs[i].sw, vecs[i].rdy);
      @(negedge clk);
      e  = exp_q.pop_front();
      nm = $sformatf("%s[%0d]", vecs[i].tag, i);
      check(nm, out_v, e);
      check_invariants(nm);
    end

    // Async reset in the middle of RD_REQ, between clock edges.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    check("clr_pre_rdreq", out_v, O_RDREQ);
    clr = 1'b0;
    #1;
    check("clr_drop_strobes", out_v, O_IDLE);
    check("clr_state_idle", {5'd0, bus.state_dbg}, 8'd0);
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("clr_no_pulse", out_v, O_IDLE);

    // Release reset and issue a write right away; first edge must take it.
    clr = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1);
    @(negedge clk); check("post_clr_mar", out_v, O_MAR);
    @(negedge clk); check("post_clr_wrreq", out_v, O_WRREQ);
    @(negedge clk); check("post_clr_done", out_v, O_DONE);
    @(negedge clk); check("post_clr_idle", out_v, O_IDLE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/memory_access_controller.md
MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles in a request state waiting for mem_ready (range 1..255).
REQ-002 Port clk  input  1: single clock, all state updates on rising edge.
REQ-003 Port clr  input  1: reset, asynchronous, active-low.
REQ-004 Port start_read  input  1: control-unit request for a memory read, sampled in IDLE only.
REQ-005 Port start_write  input  1: control-unit request for a memory write, sampled in IDLE only.
REQ-006 Port mem_ready  input  1: memory acknowledges the current read/write.
REQ-007 Port mar_en  output  1: load enable for the MAR register.
REQ-008 Port mdr_en  output  1: load enable for the MDR register.
REQ-009 Port mdr_read  output  1: MDR input mux select (1 = memory data-in, 0 = bus).
REQ-010 Port mem_read  output  1: read strobe to memory.
REQ-011 Port mem_write  output  1: write strobe to memory.
REQ-012 Port busy  output  1: high in every state except IDLE.
REQ-013 Port done  output  1: one-cycle pulse on successful completion.
REQ-014 Port err  output  1: one-cycle pulse on timeout completion.

Function
REQ-015 FSM states: IDLE, MAR_LOAD, RD_REQ, RD_LATCH, WR_REQ, DONE, ERR; all outputs Moore-decoded from the state register and the timeout counter only.
REQ-016 IDLE: start_read=1 -> MAR_LOAD with op=read; else start_write=1 -> MAR_LOAD with op=write; both high -> read wins, write request dropped (not queued).
REQ-017 start_read/start_write in any non-IDLE state are ignored.
REQ-018 MAR_LOAD: mar_en=1 for exactly one cycle; next state RD_REQ (op=read) or WR_REQ (op=write).
REQ-019 RD_REQ: mem_read=1 held; mem_ready=1 sampled -> RD_LATCH; counter reaches TIMEOUT first -> ERR.
REQ-020 RD_LATCH: mdr_read=1 and mdr_en=1 for exactly one cycle, mem_read=1 still asserted; next DONE.
REQ-021 WR_REQ: mem_write=1 held, mdr_en=0 (MDR contents frozen as write data); mem_ready=1 -> DONE; timeout -> ERR.
REQ-022 DONE: done=1 one cycle, then IDLE; ERR: err=1 one cycle, all strobes 0, then IDLE.
REQ-023 Timeout counter: 8-bit, cleared on entry to RD_REQ/WR_REQ, increments each cycle in those states while mem_ready=0; timeout when count == TIMEOUT-1 and mem_ready=0; mem_ready=1 on that same cycle wins (normal completion).
REQ-024 mem_read and mem_write never high simultaneously; mar_en never coincident with a memory strobe.
REQ-025 Best-case latency (mem_ready already high): read start sampled cycle 0, mar_en cycle 1, mem_read cycle 2, mdr_en cycle 3, done cycle 4; write done cycle 3.
REQ-026 Back-to-back: start held high through DONE begins the next operation on the first IDLE cycle (one idle cycle between operations minimum).
REQ-027 Unused state encodings transition to IDLE on the next clock.

Reset
REQ-028 clr=0 forces state IDLE, op=read, counter=0 immediately, independent of clk.
REQ-029 During reset all outputs 0: mar_en, mdr_en, mdr_read, mem_read, mem_write, busy, done, err.
REQ-030 Reset mid-operation drops active strobes the same instant; no done/err pulse generated for the aborted operation.
REQ-031 First start after clr rises is honoured on the first rising edge with clr=1.

Verification
REQ-032 Read, mem_ready tied 1: start_read pulse at cycle 0 -> mar_en@1, mem_read@2-3, mdr_read+mdr_en@3, done@4, busy 1..4.
REQ-033 Write, mem_ready rises 3 cycles into WR_REQ: mem_write held 4 cycles, mdr_en stays 0, done one cycle after ready sampled.
REQ-034 TIMEOUT=4, mem_ready held 0 on read: mem_read high 4 cycles, err pulse 1 cycle, done never asserts, returns IDLE.
REQ-035 start_read and start_write both high in IDLE -> read sequence only; write strobe never asserted.
REQ-036 clr driven low mid RD_REQ between edges -> mem_read/busy fall immediately; after release, new start_write completes normally.
REQ-037 mem_ready rises on exact timeout cycle -> normal completion (done), err stays 0.
